// File: rtl/block_motion_if.sv
// Bus bundle between the VGA timing / control side and one block_motion sprite.
// The sprite engine takes the slave side; whoever drives timing and loads takes master.
interface block_motion_if;
    logic [10:0] hst;
    logic [9:0]  vst;
    logic        run;
    logic [3:0]  step_x;
    logic [3:0]  step_y;
    logic        load_valid;
    logic [15:0] load_x;
    logic [15:0] load_y;
    logic [15:0] block_posx;
    logic [15:0] block_posy;
    logic [2:0]  draw_color;
    logic        bounce;
    logic        corner;

    modport slave (
        input  hst, vst, run, step_x, step_y, load_valid, load_x, load_y,
        output block_posx, block_posy, draw_color, bounce, corner
    );

    modport master (
        output hst, vst, run, step_x, step_y, load_valid, load_x, load_y,
        input  block_posx, block_posy, draw_color, bounce, corner
    );
endinterface

// File: rtl/block_motion.sv
// Sprite position/colour generator. Moves once per frame on the first blanking
// pixel, bounces off the screen edges and advances the colour on every bounce.
module block_motion #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int BLOCK_SIZE = 32,
    parameter int START_X    = 100,
    parameter int START_Y    = 100
) (
    input  logic           clk50,
    input  logic           rst,
    block_motion_if.slave  bus
);
    localparam int MAX_X = H_ACTIVE - BLOCK_SIZE;
    localparam int MAX_Y = V_ACTIVE - BLOCK_SIZE;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] posx_q, posx_d;
    logic [15:0] posy_q, posy_d;
    logic        dirx_q, dirx_d;      // 1 = moving towards larger coordinates
    logic        diry_q, diry_d;
    logic [2:0]  color_q, color_d;
    logic        bounce_q, bounce_d;
    logic        corner_q, corner_d;
    logic        tick;

    // First blanking pixel of the frame: the single per-frame update slot.
    assign tick = (bus.hst == 11'(H_ACTIVE)) && (bus.vst == 10'(V_ACTIVE));

    // Per-axis datapath: index 0 is X, index 1 is Y. Each axis computes its
    // candidate moved position (with edge clamp/reverse) and its clamped load value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int                 AXIS_MAX   = (gi == 0) ? MAX_X : MAX_Y;
            localparam logic signed [17:0] AXIS_MAX_S = 18'(AXIS_MAX);

            logic [3:0]         step_v;
            logic [15:0]        pos_v;
            logic [15:0]        load_v;
            logic               dir_v;
            logic signed [17:0] next_s;
            logic [15:0]        move_pos;
            logic               move_dir;
            logic               hit;
            logic [15:0]        clamp_pos;

            assign step_v = (gi == 0) ? bus.step_x : bus.step_y;
            assign pos_v  = (gi == 0) ? posx_q     : posy_q;
            assign load_v = (gi == 0) ? bus.load_x : bus.load_y;
            assign dir_v  = (gi == 0) ? dirx_q     : diry_q;

            // Signed step with wall clamp; landing exactly on a wall is not a hit.
            always_comb begin
                next_s   = $signed({2'b00, pos_v});
                move_pos = pos_v;
                move_dir = dir_v;
                hit      = 1'b0;
                if (dir_v) begin
                    next_s = next_s + $signed({14'd0, step_v});
                end else begin
                    next_s = next_s - $signed({14'd0, step_v});
                end
                if (next_s[17]) begin
                    move_pos = 16'd0;
                    move_dir = 1'b1;
                    hit      = 1'b1;
                end else if (next_s > AXIS_MAX_S) begin
                    move_pos = 16'(AXIS_MAX);
                    move_dir = 1'b0;
                    hit      = 1'b1;
                end else begin
                    move_pos = next_s[15:0];
                end
            end

            // Load request clamped into the visible range (treated as unsigned).
            assign clamp_pos = (load_v > 16'(AXIS_MAX)) ? 16'(AXIS_MAX) : load_v;
        end
    endgenerate

    // Next-state and next-output selection: load beats movement, movement only on
    // a tick while already in RUN (run as sampled on the previous cycle).
    always_comb begin
        state_d  = bus.run ? ST_RUN : ST_STOP;
        posx_d   = posx_q;
        posy_d   = posy_q;
        dirx_d   = dirx_q;
        diry_d   = diry_q;
        color_d  = color_q;
        bounce_d = 1'b0;
        corner_d = 1'b0;
        if (bus.load_valid) begin
            posx_d = g_axis[0].clamp_pos;
            posy_d = g_axis[1].clamp_pos;
        end else if (tick && (state_q == ST_RUN)) begin
            posx_d   = g_axis[0].move_pos;
            posy_d   = g_axis[1].move_pos;
            dirx_d   = g_axis[0].move_dir;
            diry_d   = g_axis[1].move_dir;
            bounce_d = g_axis[0].hit | g_axis[1].hit;
            corner_d = g_axis[0].hit & g_axis[1].hit;
            if (bounce_d) begin
                color_d = (color_q == 3'b111) ? 3'b001 : color_q + 3'd1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q  <= ST_STOP;
            posx_q   <= 16'(START_X);
            posy_q   <= 16'(START_Y);
            dirx_q   <= 1'b1;
            diry_q   <= 1'b1;
            color_q  <= 3'b001;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            dirx_q   <= dirx_d;
            diry_q   <= diry_d;
            color_q  <= color_d;
            bounce_q <= bounce_d;
            corner_q <= corner_d;
        end
    end

    assign bus.block_posx = posx_q;
    assign bus.block_posy = posy_q;
    assign bus.draw_color = color_q;
    assign bus.bounce     = bounce_q;
    assign bus.corner     = corner_q;
endmodule
